// File: rtl/comp_seq.sv
// comp_seq: chunked sequential RISC-V branch/set comparator; define COMP_SEQ_EARLY_EXIT_EN for early exit
module comp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            comp,
  output logic [XLEN-1:0] comp_out
);
  localparam int NCH = XLEN / CHUNK;
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
`ifdef COMP_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      f_q, f_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dec_q, dec_d, lt_q, lt_d, comp_q, comp_d;
  logic            sgn;
  logic [CHUNK-1:0] ac, bc;

  function automatic logic sel(input logic [2:0] f, input logic d, input logic l);
    return f == 3'b000 ? ~d : f == 3'b001 ? d : (f == 3'b101 || f == 3'b111) ? ~l : l;
  endfunction

  assign sgn       = funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b101;
  assign ac        = a_q[cnt_q*CHUNK +: CHUNK];
  assign bc        = b_q[cnt_q*CHUNK +: CHUNK];
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign comp      = out_valid & comp_q;
  assign comp_out  = {{(XLEN-1){1'b0}}, comp};

  // Next-state: latch on accept, scan chunks MSB-first, hold result until consumed
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    comp_d  = comp_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a ^ {sgn, {(XLEN-1){1'b0}}};
        b_d     = b ^ {sgn, {(XLEN-1){1'b0}}};
        f_d     = funct3;
        dec_d   = 1'b0;
        lt_d    = 1'b0;
        cnt_d   = CW'(NCH - 1);
        state_d = BUSY;
      end
      BUSY: begin
        dec_d = dec_q | (ac != bc);
        lt_d  = dec_q ? lt_q : ac < bc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0 || (EARLY && dec_d)) begin
          state_d = DONE;
          cnt_d   = '0;
          comp_d  = sel(f_q, dec_d, lt_d);
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        comp_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      comp_q  <= comp_d;
    end
  end
endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: scoreboard bench for comp_seq against an arithmetic reference model
module tb_comp_seq;
  localparam int XLEN = 32, CHUNK = 8, NCH = XLEN / CHUNK;
`ifdef COMP_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic [2:0]      funct3 = '0;
  logic            in_ready, out_valid, comp;
  logic [XLEN-1:0] comp_out;

  typedef struct {logic c; int lat; int acc;} exp_t;
  exp_t q[$];
  int   checks = 0, failures = 0, cyc = 0, first = 0, rmode = 0;
  bit   seen = 0;

  comp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready),
    .comp(comp), .comp_out(comp_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f, input int acc);
    exp_t        m;
    logic        lt, eq;
    logic [31:0] d;
    eq    = x == y;
    lt    = (f == 3'd2 || f == 3'd4 || f == 3'd5) ? ($signed(x) < $signed(y)) : (x < y);
    m.c   = f == 3'd0 ? eq : f == 3'd1 ? !eq : (f == 3'd5 || f == 3'd7) ? !lt : lt;
    m.lat = NCH;
    m.acc = acc;
    d     = x ^ y;
    if (EARLY && d != 0)
      for (int i = 0; i < 32; i++) if (d[i]) m.lat = NCH - i / CHUNK;
    return m;
  endfunction

  initial forever begin
    @(posedge clk);
    #1 out_ready = rmode == 0 ? ($urandom_range(0, 3) != 0) : rmode == 2;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) seen = 0;
    else begin
      if (out_valid && !seen) begin
        seen  = 1;
        first = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", comp_out);
        end else begin
          e = q.pop_front();
          chk("comp", comp, e.c);
          chk("comp_out", comp_out, {31'b0, e.c});
          chk("latency", first - e.acc, e.lat);
        end
        seen = 0;
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f);
    int n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    funct3 = f;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      $fatal(1);
    end
    q.push_back(model(x, y, f, cyc + 1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000 $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    int n;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_comp", comp, 0);
    chk("rst_comp_out", comp_out, 0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'hFFFFFFFF, 32'h00000001, 3'b100);
    send(32'hFFFFFFFF, 32'h00000001, 3'b110);
    send(32'h80000000, 32'h7FFFFFFF, 3'b010);
    send(32'h80000000, 32'h7FFFFFFF, 3'b011);
    send(32'h12345678, 32'h12345678, 3'b000);
    send(32'h12345678, 32'h12345678, 3'b001);
    send(32'h12345678, 32'h12345678, 3'b101);
    send(32'h12345678, 32'h12345678, 3'b111);
    send(32'h01000000, 32'h00000000, 3'b110);
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      n = $urandom_range(0, 3);
      y = n == 0 ? x : n == 1 ? x ^ ($urandom & 32'hFF) : n == 2 ? x ^ 32'h80000000 : $urandom;
      send(x, y, 3'($urandom));
    end
    drain();
    rmode = 1;
    send(32'h12345678, 32'h12345678, 3'b101);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_comp", comp, 1);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    rmode = 2;
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    drain();
    send(32'hFFFFFFFF, 32'h00000001, 3'b100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_comp", comp, 0);
    chk("midrst_comp_out", comp_out, 0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rmode = 0;
    send(32'h80000000, 32'h7FFFFFFF, 3'b010);
    send(32'h00000005, 32'h00000007, 3'b111);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand width in bits; legal values 8..64.
REQ-002 SHALL have parameter CHUNK, default 8: bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have port a  input  XLEN  first operand (rs1).
REQ-008 SHALL have port b  input  XLEN  second operand (rs2 or immediate).
REQ-009 SHALL have port funct3  input  3  comparison select: 000 BEQ, 001 BNE, 010 SLT, 011 SLTU, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both high at a rising edge.
REQ-012 SHALL have port comp  output  1  comparison result.
REQ-013 SHALL have port comp_out  output  XLEN  comp zero-extended to XLEN bits.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE; in_ready is 1 only in IDLE, and out_valid is 1 only in DONE.
REQ-015 SHALL, on acceptance in IDLE, latch a, b and funct3, clear the decided and lt flags, set chunk counter to XLEN/CHUNK-1, and enter BUSY.
REQ-016 SHALL, for signed modes (010, 100, 101), invert the MSB of both latched operands so that one unsigned magnitude compare is used for all modes.
REQ-017 SHALL, at each BUSY edge, examine chunk [cnt*CHUNK +: CHUNK] MSB-first; if not yet decided and the chunks differ, set decided=1 and lt=(a_chunk<b_chunk).
REQ-018 SHALL leave BUSY for DONE at the edge that processes chunk 0; fixed latency is XLEN/CHUNK cycles from the accept edge to out_valid high.
REQ-019 SHALL compute eq=~decided, with BEQ=eq, BNE=~eq, SLT/SLTU/BLT/BLTU=lt and BGE/BGEU=~lt.
REQ-020 SHALL hold comp and comp_out registered and stable throughout DONE while out_ready is low.
REQ-021 SHALL return to IDLE at the out_valid && out_ready edge; no new request is accepted in that same cycle.
REQ-022 SHALL ignore changes on a, b, funct3 and in_valid while in BUSY or DONE.
REQ-023 SHALL drive comp and comp_out to 0 when not in DONE.
REQ-024 SHALL use full XLEN-bit unsigned magnitude compare, so no overflow flag is needed; equal operands give lt=0 in every mode.

Reset
REQ-025 SHALL, when rst_n is low, immediately force state IDLE, in_ready=1, out_valid=0, comp=0, comp_out=0, counter=0 and flags=0, independent of clk.
REQ-026 SHALL, on reset asserted mid-BUSY or mid-DONE, discard the in-flight result; the first edge after deassertion is a legal accept edge.

Configuration
REQ-027 SHALL, when COMP_SEQ_EARLY_EXIT_EN is defined, move BUSY to DONE at the edge where decided first becomes 1, giving variable latency of 1..XLEN/CHUNK cycles; equal operands still take XLEN/CHUNK cycles.
REQ-028 SHALL, when COMP_SEQ_EARLY_EXIT_EN is undefined, use the fixed latency of REQ-018, with results identical to the defined case.

Verification
REQ-029 SHALL cover BLT with a=0xFFFFFFFF and b=0x00000001 (XLEN=32, CHUNK=8) -> comp=1 after 4 cycles; BLTU with the same operands -> comp=0.
REQ-030 SHALL cover SLT with a=0x80000000 and b=0x7FFFFFFF -> comp_out=0x00000001; SLTU -> comp_out=0x00000000.
REQ-031 SHALL cover BEQ with a=b=0x12345678 -> comp=1; BNE -> comp=0; BGE and BGEU -> comp=1.
REQ-032 SHALL cover out_ready held low for 10 cycles in DONE -> out_valid and comp stable and in_ready=0; with out_ready=1, IDLE is entered on the next edge.
REQ-033 SHALL cover rst_n pulsed low mid-BUSY -> outputs reach reset values with no clock edge, and a subsequent request completes correctly.
REQ-034 SHALL cover, with COMP_SEQ_EARLY_EXIT_EN defined, BLTU with a=0x01000000 and b=0x00000000 -> out_valid 1 cycle after accept and comp=0; with the macro undefined -> 4 cycles and the same result.
